mod_memstage: RTL and testbench

- Memory-access pipeline stage; producer side of the MEM_EX register consumed by the execute stage.
- Accepts decoded, register-read instructions. Loads (MOV r64,m64 opcode 0x8B; POP 0x58-0x5F) are issued as single-beat 64-bit reads. Stores (MOV m64,r64 opcode 0x89 with memory destination) are issued as single-beat writes.
- Read data goes to load_buffer. The instruction is then presented as MEM_EX with a valid/ready handshake.

---
 rtl/mod_memstage_pkg.sv | 91 +++++++++
 rtl/mod_memstage_agen.sv | 35 +++
 rtl/mod_memstage.sv | 147 ++++++++++++++
 tb/tb_mod_memstage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_memstage_pkg.sv
// Shared pipeline types for the memory stage: ID_MEM / MEM_EX / EX_WB packets,
// opcode constants, FSM states and instruction classification helpers.
package mod_memstage_pkg;

  localparam logic [7:0] OpMovLoad  = 8'h8B;
  localparam logic [7:0] OpMovStore = 8'h89;
  localparam logic [7:0] OpPopBase  = 8'h58;
  localparam logic [7:0] OpNop      = 8'h90;
  localparam logic [7:0] OpSyscall  = 8'h05;

  typedef struct packed {
    logic [63:0] pc_contents;
    logic [63:0] data_rega;
    logic [63:0] data_regb;
    logic [63:0] data_imm;
    logic [7:0]  ctl_opcode;
    logic        twob_opcode;
    logic [7:0]  ctl_regbyte;
    logic [7:0]  ctl_rmbyte;
    logic        ctl_dep;
    logic        ctl_memdst;
    logic        sim_end;
  } id_mem_t;

  typedef struct packed {
    logic [63:0] pc_contents;
    logic [63:0] data_rega;
    logic [63:0] data_regb;
    logic [63:0] data_imm;
    logic [7:0]  ctl_opcode;
    logic        twob_opcode;
    logic [7:0]  ctl_regbyte;
    logic [7:0]  ctl_rmbyte;
    logic        ctl_dep;
    logic        ctl_memdst;
    logic        sim_end;
  } mem_ex_t;

  typedef struct packed {
    logic [63:0] pc_contents;
    logic [63:0] result;
    logic [7:0]  ctl_regbyte;
    logic        write_en;
    logic        sim_end;
  } ex_wb_t;

  typedef struct packed {
    logic cf;
    logic zf;
    logic sf;
    logic of;
  } flags_reg_t;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} mem_state_e;

  function automatic logic op_is_load(logic [7:0] op, logic twob, logic sim_end);
    return !sim_end && !twob && (op == OpMovLoad);
  endfunction

  function automatic logic op_is_pop(logic [7:0] op, logic twob, logic sim_end);
    return !sim_end && !twob && (op[7:3] == OpPopBase[7:3]);
  endfunction

  function automatic logic op_is_store(logic [7:0] op, logic twob, logic memdst,
                                       logic sim_end);
    return !sim_end && !twob && memdst && (op == OpMovStore);
  endfunction

  function automatic logic pkt_is_mem(id_mem_t p);
    return op_is_load(p.ctl_opcode, p.twob_opcode, p.sim_end) ||
           op_is_pop(p.ctl_opcode, p.twob_opcode, p.sim_end) ||
           op_is_store(p.ctl_opcode, p.twob_opcode, p.ctl_memdst, p.sim_end);
  endfunction

  function automatic mem_ex_t to_mem_ex(id_mem_t p);
    mem_ex_t m;
    m.pc_contents = p.pc_contents;
    m.data_rega   = p.data_rega;
    m.data_regb   = p.data_regb;
    m.data_imm    = p.data_imm;
    m.ctl_opcode  = p.ctl_opcode;
    m.twob_opcode = p.twob_opcode;
    m.ctl_regbyte = p.ctl_regbyte;
    m.ctl_rmbyte  = p.ctl_rmbyte;
    m.ctl_dep     = p.ctl_dep;
    m.ctl_memdst  = p.ctl_memdst;
    m.sim_end     = p.sim_end;
    return m;
  endfunction

endpackage

// File: rtl/mod_memstage_agen.sv
// Combinational address generator: classifies the held instruction and forms
// the request address, write enable and store data.
module mod_memstage_agen
  import mod_memstage_pkg::*;
#(
  parameter int unsigned AddrW = 64,
  parameter int unsigned DataW = 64
) (
  input  logic [7:0]       opcode_i,
  input  logic             twob_i,
  input  logic             memdst_i,
  input  logic             sim_end_i,
  input  logic [63:0]      rega_i,
  input  logic [63:0]      regb_i,
  input  logic [63:0]      imm_i,
  output logic [AddrW-1:0] addr_o,
  output logic             we_o,
  output logic [DataW-1:0] wdata_o
);

  logic        is_pop;
  logic        is_store;
  logic [63:0] sum;

  always_comb begin
    is_pop   = op_is_pop(opcode_i, twob_i, sim_end_i);
    is_store = op_is_store(opcode_i, twob_i, memdst_i, sim_end_i);
    // POP reads at the current RSP; everything else is base + displacement, wrapping.
    sum      = is_pop ? rega_i : rega_i + imm_i;
    addr_o   = AddrW'(sum);
    we_o     = is_store;
    wdata_o  = is_store ? DataW'(regb_i) : '0;
  end

endmodule

// File: rtl/mod_memstage.sv
// Memory-access pipeline stage: issues single-beat loads/stores and presents
// the instruction plus load data to execute over a valid/ready handshake.
module mod_memstage
  import mod_memstage_pkg::*;
#(
  parameter int unsigned AddrW = 64,
  parameter int unsigned DataW = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  id_mem_t          in_pkt,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AddrW-1:0] mem_addr,
  output logic [DataW-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [DataW-1:0] mem_rdata,
  output mem_ex_t          memex,
  output logic             memex_valid,
  input  logic             ex_ready,
  output logic [DataW-1:0] load_buffer,
  output logic             loadbuffer_done,
  output logic             memstage_active,
  output logic             store_memstage_active
);

  mem_state_e       state_q, state_d;
  id_mem_t          pkt_q, pkt_d;
  mem_ex_t          memex_q, memex_d;
  logic             memex_valid_q, memex_valid_d;
  logic [DataW-1:0] lbuf_q, lbuf_d;
  logic             lb_done_q, lb_done_d;
  logic             halted_q, halted_d;

  logic [AddrW-1:0] agen_addr;
  logic             agen_we;
  logic [DataW-1:0] agen_wdata;
  logic             busy;
  logic             accept;
  logic             rsp_done;

  mod_memstage_agen #(
    .AddrW (AddrW),
    .DataW (DataW)
  ) u_agen (
    .opcode_i  (pkt_q.ctl_opcode),
    .twob_i    (pkt_q.twob_opcode),
    .memdst_i  (pkt_q.ctl_memdst),
    .sim_end_i (pkt_q.sim_end),
    .rega_i    (pkt_q.data_rega),
    .regb_i    (pkt_q.data_regb),
    .imm_i     (pkt_q.data_imm),
    .addr_o    (agen_addr),
    .we_o      (agen_we),
    .wdata_o   (agen_wdata)
  );

  always_comb begin
    busy                  = (state_q == StReq) || (state_q == StWait);
    mem_req               = (state_q == StReq);
    mem_we                = busy & agen_we;
    mem_addr              = busy ? agen_addr : '0;
    mem_wdata             = busy ? agen_wdata : '0;
    store_memstage_active = mem_we;
    memstage_active       = (state_q != StIdle);
    in_ready              = !halted_q &&
                            ((state_q == StIdle) || ((state_q == StOut) && ex_ready));
    accept                = in_valid && in_ready;
    // A response arriving in the grant cycle completes the access immediately.
    rsp_done              = mem_rvalid &&
                            (((state_q == StReq) && mem_gnt) || (state_q == StWait));
  end

  always_comb begin
    state_d       = state_q;
    pkt_d         = pkt_q;
    memex_d       = memex_q;
    memex_valid_d = memex_valid_q;
    lbuf_d        = lbuf_q;
    lb_done_d     = lb_done_q;
    halted_d      = halted_q;

    case (state_q)
      StReq: begin
        if (mem_gnt && !mem_rvalid) state_d = StWait;
      end
      StOut: begin
        if (ex_ready) begin
          state_d       = StIdle;
          memex_valid_d = 1'b0;
          lb_done_d     = 1'b0;
        end
      end
      default: ;
    endcase

    if (rsp_done) begin
      state_d       = StOut;
      memex_d       = to_mem_ex(pkt_q);
      memex_valid_d = 1'b1;
      lb_done_d     = !agen_we;
      if (!agen_we) lbuf_d = mem_rdata;
    end

    if (accept) begin
      pkt_d = in_pkt;
      if (pkt_is_mem(in_pkt)) begin
        state_d = StReq;
      end else begin
        state_d       = StOut;
        memex_d       = to_mem_ex(in_pkt);
        memex_valid_d = 1'b1;
        lb_done_d     = 1'b0;
        if (in_pkt.sim_end) halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pkt_q         <= '0;
      memex_q       <= '0;
      memex_valid_q <= 1'b0;
      lbuf_q        <= '0;
      lb_done_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pkt_q         <= pkt_d;
      memex_q       <= memex_d;
      memex_valid_q <= memex_valid_d;
      lbuf_q        <= lbuf_d;
      lb_done_q     <= lb_done_d;
      halted_q      <= halted_d;
    end
  end

  assign memex           = memex_q;
  assign memex_valid     = memex_valid_q;
  assign load_buffer     = lbuf_q;
  assign loadbuffer_done = lb_done_q;

endmodule

// File: tb/tb_mod_memstage.sv
// Directed self-checking bench for mod_memstage.
module tb_mod_memstage;
  import mod_memstage_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  id_mem_t       in_pkt;
  logic          mem_req;
  logic          mem_we;
  logic [63:0]   mem_addr;
  logic [63:0]   mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [63:0]   mem_rdata;
  mem_ex_t       memex;
  logic          memex_valid;
  logic          ex_ready;
  logic [63:0]   load_buffer;
  logic          loadbuffer_done;
  logic          memstage_active;
  logic          store_memstage_active;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mod_memstage #(
    .AddrW (64),
    .DataW (64)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_pkt                (in_pkt),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .mem_gnt               (mem_gnt),
    .mem_rvalid            (mem_rvalid),
    .mem_rdata             (mem_rdata),
    .memex                 (memex),
    .memex_valid           (memex_valid),
    .ex_ready              (ex_ready),
    .load_buffer           (load_buffer),
    .loadbuffer_done       (loadbuffer_done),
    .memstage_active       (memstage_active),
    .store_memstage_active (store_memstage_active)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic id_mem_t mk(logic [63:0] pc, logic [7:0] op, logic [63:0] ra,
                                 logic [63:0] rb, logic [63:0] imm, logic memdst,
                                 logic send);
    id_mem_t p;
    p             = '0;
    p.pc_contents = pc;
    p.ctl_opcode  = op;
    p.data_rega   = ra;
    p.data_regb   = rb;
    p.data_imm    = imm;
    p.ctl_memdst  = memdst;
    p.sim_end     = send;
    return p;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pkt = '0; ex_ready = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_memex_valid", memex_valid, 0);
    chk("rst_memex_pc", memex.pc_contents, 0);
    chk("rst_load_buffer", load_buffer, 0);
    chk("rst_active", memstage_active, 0);
    reset = 1'b0;
    tick();

    // Non-memory ADD
    in_pkt = mk(64'h100, 8'h01, 64'd3, 64'd4, 64'd0, 1'b0, 1'b0);
    in_valid = 1'b1; ex_ready = 1'b1;
    #1 chk("add_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("add_memex_valid", memex_valid, 1);
    chk("add_memex_op", memex.ctl_opcode, 8'h01);
    chk("add_memex_regb", memex.data_regb, 64'd4);
    chk("add_mem_req", mem_req, 0);
    chk("add_lb_done", loadbuffer_done, 0);
    tick();
    chk("add_drain_valid", memex_valid, 0);
    chk("add_drain_active", memstage_active, 0);

    // Load with gnt after 2 REQ cycles, rvalid on 3rd WAIT cycle
    ex_ready = 1'b0;
    in_pkt = mk(64'h104, OpMovLoad, 64'h1000, 64'd0, 64'h10, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ld_req", mem_req, 1);
    chk("ld_addr", mem_addr, 64'h1010);
    chk("ld_we", mem_we, 0);
    chk("ld_in_ready", in_ready, 0);
    tick();
    chk("ld_req_hold", mem_req, 1);
    chk("ld_addr_hold", mem_addr, 64'h1010);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("ld_req_drop", mem_req, 0);
    chk("ld_wait_valid", memex_valid, 0);
    tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 64'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 64'h0;
    chk("ld_memex_valid", memex_valid, 1);
    chk("ld_load_buffer", load_buffer, 64'hDEADBEEF);
    chk("ld_lb_done", loadbuffer_done, 1);
    chk("ld_memex_op", memex.ctl_opcode, OpMovLoad);

    // Stall in OUT for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", memex_valid, 1);
      chk("stall_pc", memex.pc_contents, 64'h104);
      chk("stall_lbuf", load_buffer, 64'hDEADBEEF);
      chk("stall_in_ready", in_ready, 0);
    end

    // Back-to-back store accepted on the ex_ready pulse
    in_pkt = mk(64'h108, OpMovStore, 64'h2000, 64'h55, 64'd0, 1'b1, 1'b0);
    in_valid = 1'b1; ex_ready = 1'b1;
    #1 chk("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; ex_ready = 1'b0;
    chk("st_memex_valid", memex_valid, 0);
    chk("st_lb_done_clr", loadbuffer_done, 0);
    chk("st_req", mem_req, 1);
    chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 64'h55);
    chk("st_addr", mem_addr, 64'h2000);
    chk("st_active", store_memstage_active, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("st_wait_active", store_memstage_active, 1);
    chk("st_wait_req", mem_req, 0);
    mem_rvalid = 1'b1; mem_rdata = 64'hBAD0;
    tick();
    mem_rvalid = 1'b0;
    chk("st_out_valid", memex_valid, 1);
    chk("st_out_active", store_memstage_active, 0);
    chk("st_lb_done", loadbuffer_done, 0);
    chk("st_lbuf_kept", load_buffer, 64'hDEADBEEF);
    ex_ready = 1'b1;
    tick();

    // Address wrap, response in the grant cycle
    in_pkt = mk(64'h10C, OpMovLoad, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'h10, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("wrap_addr", mem_addr, 64'h8);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h1234;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("gntrv_valid", memex_valid, 1);
    chk("gntrv_lbuf", load_buffer, 64'h1234);
    tick();

    // POP then reset in WAIT with a stray late response
    in_pkt = mk(64'h110, 8'h5C, 64'h7FF0, 64'd0, 64'h8, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pop_addr", mem_addr, 64'h7FF0);
    chk("pop_we", mem_we, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hBADBAD;
    chk("mrst_active", memstage_active, 0);
    chk("mrst_lbuf", load_buffer, 0);
    tick();
    mem_rvalid = 1'b0;
    chk("stray_lbuf", load_buffer, 0);
    chk("stray_lb_done", loadbuffer_done, 0);
    chk("stray_valid", memex_valid, 0);
    chk("stray_active", memstage_active, 0);
    chk("stray_in_ready", in_ready, 1);

    // NOP, syscall, sim_end back-to-back
    in_pkt = mk(64'h200, OpNop, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    chk("nop_op", memex.ctl_opcode, OpNop);
    in_pkt = mk(64'h201, OpSyscall, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    tick();
    chk("sys_op", memex.ctl_opcode, OpSyscall);
    chk("sys_valid", memex_valid, 1);
    in_pkt = mk(64'h203, OpMovLoad, 64'h40, 64'd0, 64'd0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("end_sim_end", memex.sim_end, 1);
    chk("end_mem_req", mem_req, 0);
    chk("end_in_ready", in_ready, 0);
    tick();
    chk("halt_in_ready", in_ready, 0);
    chk("halt_valid", memex_valid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("unhalt_in_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
